forward_hazard_ctrl: RTL and testbench
======================================

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_W, default 3: register-index width, giving 8 registers R0–R7, all forwardable.
REQ-002 The block SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 id_valid  in  1  decode-stage instruction valid.
REQ-006 id_src1, id_src2  in  REG_W  source register indices.
REQ-007 id_use_src1, id_use_src2  in  1  operand actually read from register file.
REQ-008 id_use_imm  in  1  operand 2 is the shift amount, not a register.
REQ-009 id_dest  in  REG_W  destination index; id_reg_write  in  1  writes a register.
REQ-010 id_mem_read  in  1  instruction is a load or pop; data is ready only after MEM.
REQ-011 mem_stall  in  1  memory stage busy; freezes the whole pipeline.
REQ-012 flush  in  1  taken branch or interrupt; kills the ID and EX instructions.
REQ-013 alu_src1_select, alu_src2_select  out  2  EX operand mux: 00 WB data, 01 MEM-stage data, 10 register file/src mux, 11 unused.
REQ-014 alu_src_select  out  1  EX operand-2 source: 0 register, 1 shamt.
REQ-015 stall_fetch  out  1  hold PC and IF/ID this cycle (combinational).
REQ-016 ex_bubble  out  1  the EX-stage op is a NOP; suppresses ALU flag and register writes.
REQ-017 stall_count  out  CNT_W  load-use stall cycles since reset, saturating.

Function
REQ-018 The block SHALL track two shadow stages: EX (vld, dest, wr, ld) and MEM (vld, dest, wr).
REQ-019 Selects SHALL be registered: computed from the ID inputs in cycle t and presented during EX in cycle t+1 (latency 1).
REQ-020 Operand N is in use when id_valid & id_use_srcN; operand 2 is never in use when id_use_imm=1.
REQ-021 Match-EX(N) SHALL be: operand N in use & ex_vld & ex_wr & ex_dest==id_srcN; Match-MEM(N) is the same against the MEM shadow stage.
REQ-022 Operand select priority SHALL be: Match-EX & !ex_ld -> 01, else Match-MEM -> 00, else 10.
REQ-023 alu_src_select SHALL be registered as id_use_imm; when it is 1, alu_src2_select SHALL be 10.
REQ-024 A load-use hazard SHALL be Match-EX(1 or 2) & ex_ld & !flush.
REQ-025 On a load-use hazard: stall_fetch=1; the EX shadow becomes a bubble and ex_bubble=1 next cycle; the MEM shadow takes the old EX entry.
REQ-026 The retried ID instruction SHALL then resolve the load via Match-MEM (select 00).
REQ-027 On a normal advance: MEM<-EX; EX<-ID fields, with vld=id_valid.
REQ-028 On flush=1: the EX shadow loads a bubble (vld=0), ex_bubble=1 next cycle, MEM<-EX as normal, and no stall is raised even if a hazard exists.
REQ-029 mem_stall=1 SHALL override everything: all state and outputs hold, stall_fetch=1, and stall_count does not increment.
REQ-030 stall_count SHALL increment once per load-use stall cycle and saturate at all-ones.
REQ-031 Matches against the EX and MEM shadow stages SHALL be ignored when their vld=0.

Reset
REQ-032 While rst_n=0 at posedge clk: shadow vld bits=0, selects=10, alu_src_select=0, ex_bubble=1, stall_count=0.
REQ-033 While rst_n=0, stall_fetch SHALL be 0.
REQ-034 Reset mid-stall SHALL discard the pending hazard; the first cycle after reset shall produce no stall.

Structure
REQ-035 A shared package SHALL hold the operand-select enum (FWD_WB=00, FWD_MEM=01, FWD_REG=10) and the REG_W/CNT_W defaults; the datapath shall import it.
REQ-036 A single sub-module, fwd_match, SHALL compute the priority select for one operand and be instanced twice.

Verification
REQ-037 Test ADD R1 then ADD R2,R1,R3 back-to-back -> alu_src1_select=01 in the consumer's EX cycle, no stall.
REQ-038 Test a producer of R1, one unrelated instruction, then a consumer of R1 -> select 00.
REQ-039 Test R1 written by both the MEM and WB shadow stages -> select 01 (newest data wins).
REQ-040 Test LDD R4 then AND R5,R4,R4 -> stall_fetch=1 for one cycle, ex_bubble=1, both selects 00 on retry, stall_count=1.
REQ-041 Test a load-use hazard with flush=1 in the same cycle -> stall_fetch=0, ex_bubble=1 next cycle, stall_count unchanged.
REQ-042 Test SHL R2,#3 with R2 produced in EX -> alu_src1_select=01, alu_src_select=1, alu_src2_select=10; also mem_stall held 3 cycles -> all outputs frozen.

Source files
------------

// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared types and defaults for the forwarding / hazard control block.
package forward_hazard_ctrl_pkg;

  localparam int unsigned REG_W_DEF = 3;
  localparam int unsigned CNT_W_DEF = 16;

  // EX operand mux select encoding
  typedef enum logic [1:0] {
    FWD_WB  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_REG = 2'b10
  } fwd_sel_e;

endpackage : forward_hazard_ctrl_pkg

// File: rtl/forward_hazard_ctrl_fwd_match.sv
// Per-operand match against the EX/MEM shadow stages and priority select.
module fwd_match
  import forward_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             op_in_use,
  input  logic [REG_W-1:0] op_src,
  input  logic             ex_vld,
  input  logic             ex_wr,
  input  logic             ex_ld,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_vld,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] mem_dest,
  output logic [1:0]       sel_c,
  output logic             match_ex_c
);

  logic match_mem_c;

  // Newest producer wins; a load in EX cannot forward yet and falls to MEM/reg
  always_comb begin
    match_ex_c  = op_in_use & ex_vld & ex_wr & (ex_dest == op_src);
    match_mem_c = op_in_use & mem_vld & mem_wr & (mem_dest == op_src);
    sel_c       = 2'(FWD_REG);
    if (match_ex_c && !ex_ld) begin
      sel_c = 2'(FWD_MEM);
    end else if (match_mem_c) begin
      sel_c = 2'(FWD_WB);
    end
  end

endmodule : fwd_match

// File: rtl/forward_hazard_ctrl.sv
// Forwarding select generation and load-use stall control for a 5-stage pipe.
module forward_hazard_ctrl
  import forward_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             id_use_imm,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             mem_stall,
  input  logic             flush,
  output logic [1:0]       alu_src1_select,
  output logic [1:0]       alu_src2_select,
  output logic             alu_src_select,
  output logic             stall_fetch,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count
);

  // Shadow stage state
  logic             ex_vld_q,  ex_vld_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;
  logic             ex_wr_q,   ex_wr_d;
  logic             ex_ld_q,   ex_ld_d;
  logic             mem_vld_q,  mem_vld_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic             mem_wr_q,   mem_wr_d;

  // Registered outputs
  fwd_sel_e         src1_sel_q, src1_sel_d;
  fwd_sel_e         src2_sel_q, src2_sel_d;
  logic             alu_src_sel_q, alu_src_sel_d;
  logic             ex_bubble_q, ex_bubble_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             op1_in_use_c, op2_in_use_c;
  logic [1:0]       sel1_c, sel2_c;
  logic             match_ex1_c, match_ex2_c;
  logic             load_use_c;

  // Operand usage: an immediate shift amount replaces operand 2
  always_comb begin
    op1_in_use_c = id_valid & id_use_src1;
    op2_in_use_c = id_valid & id_use_src2 & ~id_use_imm;
  end

  fwd_match #(.REG_W(REG_W)) u_fwd_match_src1 (
    .op_in_use  (op1_in_use_c),
    .op_src     (id_src1),
    .ex_vld     (ex_vld_q),
    .ex_wr      (ex_wr_q),
    .ex_ld      (ex_ld_q),
    .ex_dest    (ex_dest_q),
    .mem_vld    (mem_vld_q),
    .mem_wr     (mem_wr_q),
    .mem_dest   (mem_dest_q),
    .sel_c      (sel1_c),
    .match_ex_c (match_ex1_c)
  );

  fwd_match #(.REG_W(REG_W)) u_fwd_match_src2 (
    .op_in_use  (op2_in_use_c),
    .op_src     (id_src2),
    .ex_vld     (ex_vld_q),
    .ex_wr      (ex_wr_q),
    .ex_ld      (ex_ld_q),
    .ex_dest    (ex_dest_q),
    .mem_vld    (mem_vld_q),
    .mem_wr     (mem_wr_q),
    .mem_dest   (mem_dest_q),
    .sel_c      (sel2_c),
    .match_ex_c (match_ex2_c)
  );

  // Load-use hazard and fetch hold; reset masks everything, mem_stall freezes the pipe
  always_comb begin
    load_use_c  = (match_ex1_c | match_ex2_c) & ex_ld_q & ~flush;
    stall_fetch = 1'b0;
    if (rst_n) begin
      stall_fetch = mem_stall | load_use_c;
    end
  end

  // Next-state: hold on mem_stall, bubble on hazard/flush, otherwise advance
  always_comb begin
    ex_vld_d      = ex_vld_q;
    ex_dest_d     = ex_dest_q;
    ex_wr_d       = ex_wr_q;
    ex_ld_d       = ex_ld_q;
    mem_vld_d     = mem_vld_q;
    mem_dest_d    = mem_dest_q;
    mem_wr_d      = mem_wr_q;
    src1_sel_d    = src1_sel_q;
    src2_sel_d    = src2_sel_q;
    alu_src_sel_d = alu_src_sel_q;
    ex_bubble_d   = ex_bubble_q;
    stall_count_d = stall_count_q;

    if (!rst_n) begin
      ex_vld_d      = 1'b0;
      ex_dest_d     = '0;
      ex_wr_d       = 1'b0;
      ex_ld_d       = 1'b0;
      mem_vld_d     = 1'b0;
      mem_dest_d    = '0;
      mem_wr_d      = 1'b0;
      src1_sel_d    = FWD_REG;
      src2_sel_d    = FWD_REG;
      alu_src_sel_d = 1'b0;
      ex_bubble_d   = 1'b1;
      stall_count_d = '0;
    end else if (!mem_stall) begin
      mem_vld_d  = ex_vld_q;
      mem_dest_d = ex_dest_q;
      mem_wr_d   = ex_wr_q;
      if (load_use_c || flush) begin
        ex_vld_d      = 1'b0;
        ex_wr_d       = 1'b0;
        ex_ld_d       = 1'b0;
        src1_sel_d    = FWD_REG;
        src2_sel_d    = FWD_REG;
        alu_src_sel_d = 1'b0;
        ex_bubble_d   = 1'b1;
        if (load_use_c && (stall_count_q != '1)) begin
          stall_count_d = stall_count_q + CNT_W'(1);
        end
      end else begin
        ex_vld_d      = id_valid;
        ex_dest_d     = id_dest;
        ex_wr_d       = id_reg_write;
        ex_ld_d       = id_mem_read;
        src1_sel_d    = fwd_sel_e'(sel1_c);
        src2_sel_d    = id_use_imm ? FWD_REG : fwd_sel_e'(sel2_c);
        alu_src_sel_d = id_use_imm;
        ex_bubble_d   = ~id_valid;
      end
    end
  end

  // State register with synchronous active-low reset folded into next-state
  always_ff @(posedge clk) begin
    ex_vld_q      <= ex_vld_d;
    ex_dest_q     <= ex_dest_d;
    ex_wr_q       <= ex_wr_d;
    ex_ld_q       <= ex_ld_d;
    mem_vld_q     <= mem_vld_d;
    mem_dest_q    <= mem_dest_d;
    mem_wr_q      <= mem_wr_d;
    src1_sel_q    <= src1_sel_d;
    src2_sel_q    <= src2_sel_d;
    alu_src_sel_q <= alu_src_sel_d;
    ex_bubble_q   <= ex_bubble_d;
    stall_count_q <= stall_count_d;
  end

  // Output drive
  always_comb begin
    alu_src1_select = src1_sel_q;
    alu_src2_select = src2_sel_q;
    alu_src_select  = alu_src_sel_q;
    ex_bubble       = ex_bubble_q;
    stall_count     = stall_count_q;
  end

endmodule : forward_hazard_ctrl

// File: tb/tb_forward_hazard_ctrl.sv
// Directed bench for forward_hazard_ctrl: forwarding selects, load-use stall, flush, mem_stall, reset.
module tb_forward_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_src1, id_src2, id_dest;
  logic        id_use_src1, id_use_src2, id_use_imm;
  logic        id_reg_write, id_mem_read;
  logic        mem_stall, flush;
  logic [1:0]  alu_src1_select, alu_src2_select;
  logic        alu_src_select, stall_fetch, ex_bubble;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  forward_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_use_src1     (id_use_src1),
    .id_use_src2     (id_use_src2),
    .id_use_imm      (id_use_imm),
    .id_dest         (id_dest),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .mem_stall       (mem_stall),
    .flush           (flush),
    .alu_src1_select (alu_src1_select),
    .alu_src2_select (alu_src2_select),
    .alu_src_select  (alu_src_select),
    .stall_fetch     (stall_fetch),
    .ex_bubble       (ex_bubble),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // valid, src1, src2, use1, use2, imm, dest, wr, ld
  task automatic set_id(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                        input logic u1, input logic u2, input logic imm,
                        input logic [2:0] d, input logic wr, input logic ld);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_use_src1 = u1; id_use_src2 = u2;
    id_use_imm = imm; id_dest = d; id_reg_write = wr; id_mem_read = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; mem_stall = 1'b1; flush = 1'b0;
    set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    #2;
    chk("rst_stall_fetch", 32'(stall_fetch), 32'd0);
    tick(); tick();
    chk("rst_sel1", 32'(alu_src1_select), 32'd2);
    chk("rst_sel2", 32'(alu_src2_select), 32'd2);
    chk("rst_alu_src", 32'(alu_src_select), 32'd0);
    chk("rst_bubble", 32'(ex_bubble), 32'd1);
    chk("rst_count", 32'(stall_count), 32'd0);
    mem_stall = 1'b0; rst_n = 1'b1;
    idle(2);

    // ADD R1 ; ADD R2,R1,R3 -> src1 from MEM stage
    set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0); tick();
    set_id(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
    #1 chk("b2b_no_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("b2b_sel1", 32'(alu_src1_select), 32'd1);
    chk("b2b_sel2", 32'(alu_src2_select), 32'd2);
    chk("b2b_bubble", 32'(ex_bubble), 32'd0);
    idle(2);

    // producer R1, unrelated, consumer of R1 on operand 2 -> WB
    set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0); tick();
    set_id(1'b1, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0); tick();
    set_id(1'b1, 3'd7, 3'd1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0); tick();
    chk("gap1_sel2", 32'(alu_src2_select), 32'd0);
    chk("gap1_sel1", 32'(alu_src1_select), 32'd2);
    idle(2);

    // R1 written twice in a row: newest (MEM stage) wins
    set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0); tick();
    set_id(1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0); tick();
    set_id(1'b1, 3'd1, 3'd6, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0); tick();
    chk("newest_sel1", 32'(alu_src1_select), 32'd1);
    idle(2);

    // LDD R4 ; AND R5,R4,R4 -> one stall, bubble, retry via WB
    set_id(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1); tick();
    set_id(1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
    #1 chk("lu_stall", 32'(stall_fetch), 32'd1);
    tick();
    chk("lu_bubble", 32'(ex_bubble), 32'd1);
    chk("lu_count", 32'(stall_count), 32'd1);
    chk("lu_retry_no_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("lu_retry_sel1", 32'(alu_src1_select), 32'd0);
    chk("lu_retry_sel2", 32'(alu_src2_select), 32'd0);
    chk("lu_retry_bubble", 32'(ex_bubble), 32'd0);
    idle(2);

    // load-use with flush in the same cycle -> no stall, bubble, count unchanged
    set_id(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1); tick();
    set_id(1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
    flush = 1'b1;
    #1 chk("fl_no_stall", 32'(stall_fetch), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_bubble", 32'(ex_bubble), 32'd1);
    chk("fl_count", 32'(stall_count), 32'd1);
    idle(2);

    // ADD R2 ; SHL R2,#3 -> src1 MEM, immediate operand 2
    set_id(1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0); tick();
    set_id(1'b1, 3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0); tick();
    chk("shl_sel1", 32'(alu_src1_select), 32'd1);
    chk("shl_alu_src", 32'(alu_src_select), 32'd1);
    chk("shl_sel2", 32'(alu_src2_select), 32'd2);

    // mem_stall for 3 cycles: everything frozen, fetch held
    set_id(1'b1, 3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 1'b1);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ms_stall_fetch", 32'(stall_fetch), 32'd1);
      tick();
      chk("ms_sel1", 32'(alu_src1_select), 32'd1);
      chk("ms_sel2", 32'(alu_src2_select), 32'd2);
      chk("ms_alu_src", 32'(alu_src_select), 32'd1);
      chk("ms_bubble", 32'(ex_bubble), 32'd0);
      chk("ms_count", 32'(stall_count), 32'd1);
    end
    mem_stall = 1'b0;
    idle(2);

    // reset while a load-use hazard is pending discards it
    set_id(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1); tick();
    set_id(1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
    #1 chk("rs_pre_stall", 32'(stall_fetch), 32'd1);
    rst_n = 1'b0;
    #1 chk("rs_in_reset", 32'(stall_fetch), 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("rs_after_no_stall", 32'(stall_fetch), 32'd0);
    chk("rs_count", 32'(stall_count), 32'd0);
    chk("rs_bubble", 32'(ex_bubble), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_forward_hazard_ctrl
